// File: rtl/sram_sp_be_reg_flag.sv
// sram_sp_be_reg_flag: register RAM with per-column write enables and per-column written flags cleared by prev_start_i.
// Define SRAM_SANITY_CHECK_EN to enable simulation-only parameter checks after reset.
module sram_sp_be_reg_flag #(
  parameter int KNOB_REGOUT = -1,
  parameter int SIZE        = -1,
  parameter int SIZE_COL    = -1,
  parameter int DATA_WD     = -1,
  localparam int SIZE_WD    = (SIZE > 2) ? $clog2(SIZE) : 1,
  localparam int DW         = (DATA_WD > 0) ? DATA_WD : 1,
  localparam int SC         = (SIZE_COL > 0 && SIZE_COL <= DW) ? SIZE_COL : DW,
  localparam int NUMB_COL   = DW / SC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                prev_start_i,
  input  logic [SIZE_WD-1:0]  adr_i,
  input  logic [NUMB_COL-1:0] wr_val_i,
  input  logic [DW-1:0]       wr_dat_i,
  input  logic                rd_val_i,
  output logic                rd_val_o,
  output logic [DW-1:0]       rd_dat_o
);
  localparam int SMAX = (SIZE > 2) ? SIZE : 2;
  logic [DW-1:0]       mem  [SMAX];
  logic [NUMB_COL-1:0] flag [SMAX];
  logic                in_rng;
  logic [SIZE_WD-1:0]  adr_c;
  logic [DW-1:0]       rd_word;
  logic                s1_val;
  logic [DW-1:0]       s1_dat;
  assign in_rng = 32'(adr_i) < SMAX;
  assign adr_c  = in_rng ? adr_i : '0;
  // unflagged columns read as zero; out-of-range addresses read as all zeros
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUMB_COL; k++)
      rd_word[k*SC +: SC] = (in_rng && flag[adr_c][k]) ? mem[adr_c][k*SC +: SC] : '0;
  end
  always_ff @(posedge clk)
    if (!rstn && in_rng)
      for (int k = 0; k < NUMB_COL; k++)
        if (wr_val_i[k]) mem[adr_c][k*SC +: SC] <= wr_dat_i[k*SC +: SC];
  // a write in the start cycle lands after the clear, so its columns stay flagged
  always_ff @(posedge clk)
    if (rstn)
      for (int i = 0; i < SMAX; i++) flag[i] <= '0;
    else begin
      if (prev_start_i)
        for (int i = 0; i < SMAX; i++) flag[i] <= '0;
      if (in_rng)
        for (int k = 0; k < NUMB_COL; k++)
          if (wr_val_i[k]) flag[adr_c][k] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (rstn) begin
      s1_val <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_val <= rd_val_i;
      if (rd_val_i) s1_dat <= rd_word;
    end
  if (KNOB_REGOUT == 1) begin : g_regout
    always_ff @(posedge clk)
      if (rstn) begin
        rd_val_o <= 1'b0;
        rd_dat_o <= '0;
      end else begin
        rd_val_o <= s1_val;
        if (s1_val) rd_dat_o <= s1_dat;
      end
  end else begin : g_direct
    assign rd_val_o = s1_val;
    assign rd_dat_o = s1_dat;
  end
`ifdef SRAM_SANITY_CHECK_EN
  always @(negedge rstn)
    if (!(KNOB_REGOUT inside {0, 1}) || SIZE < 2 || SIZE_COL <= 0 || (DATA_WD % SIZE_COL) != 0) begin
      $error("%m: illegal parameters KNOB_REGOUT=%0d SIZE=%0d SIZE_COL=%0d DATA_WD=%0d",
             KNOB_REGOUT, SIZE, SIZE_COL, DATA_WD);
      #1000 $finish;
    end
`endif
endmodule

// File: tb/tb_sram_sp_be_reg_flag.sv
// tb_sram_sp_be_reg_flag: directed and random checks of both latency variants against a behavioural model.
module tb_sram_sp_be_reg_flag;
  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, rv = 1'b0;
  logic [3:0]  adr = '0, wv = '0;
  logic [31:0] wd = '0;
  logic        val0, val1;
  logic [31:0] dat0, dat1;
  int          n = 0, err = 0;
  logic [31:0] mmem [2][16];
  logic [3:0]  mflg [2][16];
  logic [32:0] q0[$], q1[$];
  logic        ev [2];
  logic [31:0] ed [2];
  int          sz [2] = '{16, 12};
  always #5 clk = ~clk;
  sram_sp_be_reg_flag #(.KNOB_REGOUT(0), .SIZE(16), .SIZE_COL(8), .DATA_WD(32)) u0 (
    .clk(clk), .rstn(rst), .prev_start_i(start), .adr_i(adr), .wr_val_i(wv),
    .wr_dat_i(wd), .rd_val_i(rv), .rd_val_o(val0), .rd_dat_o(dat0));
  sram_sp_be_reg_flag #(.KNOB_REGOUT(1), .SIZE(12), .SIZE_COL(8), .DATA_WD(32)) u1 (
    .clk(clk), .rstn(rst), .prev_start_i(start), .adr_i(adr), .wr_val_i(wv),
    .wr_dat_i(wd), .rd_val_i(rv), .rd_val_o(val1), .rd_dat_o(dat1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] peek(int i, logic [3:0] a);
    logic [31:0] r = '0;
    if (int'(a) < sz[i])
      for (int k = 0; k < 4; k++) if (mflg[i][a][k]) r[k*8 +: 8] = mmem[i][a][k*8 +: 8];
    return r;
  endfunction
  task automatic model(int i, logic r, logic s, logic [3:0] a, logic [3:0] w, logic [31:0] d, logic rd);
    logic [32:0] e, p;
    int qs;
    if (r) begin
      for (int j = 0; j < 16; j++) mflg[i][j] = '0;
      if (i == 0) q0.delete(); else q1.delete();
      ev[i] = 1'b0;
      ed[i] = '0;
      return;
    end
    e = {rd, peek(i, a)};
    if (s) for (int j = 0; j < 16; j++) mflg[i][j] = '0;
    if (int'(a) < sz[i])
      for (int k = 0; k < 4; k++)
        if (w[k]) begin
          mmem[i][a][k*8 +: 8] = d[k*8 +: 8];
          mflg[i][a][k] = 1'b1;
        end
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    qs = (i == 0) ? q0.size() : q1.size();
    ev[i] = 1'b0;
    if (qs >= i + 1) begin
      p = (i == 0) ? q0.pop_front() : q1.pop_front();
      ev[i] = p[32];
      if (p[32]) ed[i] = p[31:0];
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic [3:0] a, input logic [3:0] w,
                     input logic [31:0] d, input logic rd);
    rst = r; start = s; adr = a; wv = w; wd = d; rv = rd;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model(i, r, s, a, w, d, rd);
    @(negedge clk);
    check("val0", {31'b0, val0}, {31'b0, ev[0]});
    check("dat0", dat0, ed[0]);
    check("val1", {31'b0, val1}, {31'b0, ev[1]});
    check("dat1", dat1, ed[1]);
  endtask
  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) begin
        mmem[i][j] = '0;
        mflg[i][j] = '0;
      end
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    check("rst_dat0", dat0, 32'h0);
    cyc(0, 0, 3, 4'hF, 32'hAABBCCDD, 0);
    cyc(0, 0, 3, 0, 0, 1);
    check("full_wr", dat0, 32'hAABBCCDD);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 5, 4'b0101, 32'h11223344, 0);
    cyc(0, 0, 5, 0, 0, 1);
    check("part_wr", dat0, 32'h00220044);
    cyc(0, 0, 7, 4'hF, 32'hFFFFFFFF, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 7, 0, 0, 1);
    check("start_clr", dat0, 32'h0);
    cyc(0, 1, 7, 4'hF, 32'h12345678, 0);
    cyc(0, 0, 7, 0, 0, 1);
    check("start_wr", dat0, 32'h12345678);
    cyc(0, 1, 9, 4'hF, 32'h55555555, 1);
    check("start_rd", dat0, 32'h0);
    cyc(0, 0, 2, 4'hF, 32'h1, 0);
    cyc(0, 0, 2, 4'hF, 32'h2, 1);
    check("rbw_old", dat0, 32'h1);
    cyc(0, 0, 2, 0, 0, 1);
    check("rbw_new", dat0, 32'h2);
    cyc(0, 0, 12, 4'hF, 32'hCAFEF00D, 0);
    cyc(0, 0, 12, 0, 0, 1);
    check("oor_rd0", dat0, 32'hCAFEF00D);
    cyc(0, 0, 0, 0, 0, 0);
    check("oor_val1", {31'b0, val1}, 32'h1);
    check("oor_dat1", dat1, 32'h0);
    for (int j = 0; j < 4; j++) cyc(0, 0, 4'(j), 4'hF, 32'(32'h10 + j), 0);
    for (int j = 0; j < 5; j++) begin
      cyc(0, 0, 4'(j), 0, 0, j < 4);
      if (j >= 1) check("pipe1", dat1, 32'(32'h10 + j - 1));
    end
    cyc(0, 0, 3, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("mid_rst_v1", {31'b0, val1}, 32'h0);
    check("mid_rst_d1", dat1, 32'h0);
    cyc(0, 0, 3, 0, 0, 1);
    check("post_rst0", dat0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("post_rst1", dat1, 32'h0);
    for (int t = 0; t < 600; t++)
      cyc($urandom_range(49) == 0, $urandom_range(9) == 0, 4'($urandom), 4'($urandom),
          $urandom, 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/sram_sp_be_reg_flag.md
# sram_sp_be_reg_flag

Register-based single-port RAM with per-column write enables and a per-column "written" flag array. A frame/task start pulse invalidates all contents in one cycle, so reads of columns not written since the last start return zero. Used as a leaf storage element, either directly or replicated per bank inside multi-bank wrappers that gate `prev_start_i`, `wr_val_i` and `rd_val_i` by bank index.

## Interface
- `KNOB_REGOUT`, -1: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency; -1 = unconfigured (illegal).
- `SIZE`, -1: number of words (≥2).
- `SIZE_COL`, -1: bits per write-enable column; `DATA_WD` must be a multiple of it.
- `DATA_WD`, -1: word width.
- Derived: `SIZE_WD` = ceil(log2(SIZE)); `NUMB_COL` = DATA_WD/SIZE_COL.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rstn`  in  1  reset; one clock; reset is synchronous and active-high (port keeps codebase name `rstn`; asserted = 1).
- `prev_start_i`  in  1  single-cycle start pulse; clears all written flags.
- `adr_i`  in  SIZE_WD  word address, shared by read and write.
- `wr_val_i`  in  NUMB_COL  per-column write enable; bit k covers `wr_dat_i[SIZE_COL*(k+1)-1 : SIZE_COL*k]`.
- `wr_dat_i`  in  DATA_WD  write data.
- `rd_val_i`  in  1  read request.
- `rd_val_o`  out  1  read data valid.
- `rd_dat_o`  out  DATA_WD  read data.

## Operation
- Storage: SIZE × DATA_WD data registers (not reset) plus SIZE × NUMB_COL flag bits (reset to 0).
- Write: for each k with `wr_val_i[k]`=1, column k of word `adr_i` takes the new data and its flag is set.
- Read: on `rd_val_i`=1, word `adr_i` is sampled; each column returns stored data if its flag is 1, else zeros.
- `prev_start_i`=1 clears every flag. A write in the same cycle applies after the clear: its columns end up flagged with new data.
- A read in the same cycle as `prev_start_i` sees pre-clear flags.
- A read and write to the same address in the same cycle return old data/flags (read-before-write).
- `adr_i` ≥ SIZE: write ignored; read returns all zeros with normal `rd_val_o`.
- Without a read request, `rd_dat_o` holds its last value.

## Timing
- KNOB_REGOUT=0: `rd_val_o` = `rd_val_i` delayed 1 cycle; `rd_dat_o` valid in the same cycle.
- KNOB_REGOUT=1: `rd_val_o` = `rd_val_i` delayed 2 cycles; output data register loads only when the stage-1 valid is 1.
- Back-to-back reads are accepted every cycle with no bubbles.
- Reset: `rd_val_o`=0, `rd_dat_o`=0, all pipeline registers 0, all flags 0. Reset mid-read drops in-flight valids. Writes, reads and `prev_start_i` are ignored while reset is asserted.

## Configuration
- `SRAM_SANITY_CHECK_EN` defined: simulation-only checks run after reset deasserts. Checked conditions: KNOB_REGOUT not in {0,1}; SIZE < 2; DATA_WD % SIZE_COL ≠ 0. On failure, print an error containing the instance path (`%m`) and call `$finish` after 1000 time units.
- Undefined: no checks; the synthesized logic is identical either way.

## Test plan
- Parameters DATA_WD=32, SIZE_COL=8, SIZE=16, KNOB_REGOUT=0. Write 0xAABBCCDD to adr 3 with `wr_val_i`=4'hF, then read adr 3 → next cycle `rd_val_o`=1, `rd_dat_o`=0xAABBCCDD.
- Partial write: pulse `prev_start_i`, then write 0x11223344 to adr 5 with `wr_val_i`=4'b0101; read adr 5 → 0x00220044.
- Start clears flags: write adr 7 = 0xFFFFFFFF, pulse `prev_start_i`, read adr 7 → 0x00000000. Write and start in the same cycle, then read → written data.
- Same-cycle read/write to adr 2: old value 0x1, new value 0x2 → read returns 0x1; next read returns 0x2.
- KNOB_REGOUT=1 with reads on 4 consecutive cycles (adr 0..3 preloaded with 0x10..0x13) → `rd_val_o` high 2 cycles after each request; data 0x10..0x13 in order.
- Reset asserted between a read request and its response → `rd_val_o`=0 and `rd_dat_o`=0; after reset, any read returns 0.
